// File: rtl/updown_counter_mod.sv
// Modulo-N up/down counter with programmable step, load, wrap/saturate boundary mode
// and registered boundary-crossing (ovf) and illegal-value (err) pulses.
module updown_counter_mod #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned MODULUS = 200
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             en,
    input  logic             ud,
    input  logic             sat,
    input  logic [WIDTH-1:0] step,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             ovf,
    output logic             err,
    output logic             at_max,
    output logic             at_min
);

    // One extra bit so MODULUS == 2^WIDTH and up-count sums compare without truncation.
    localparam logic [WIDTH:0]   ModExt = (WIDTH + 1)'(MODULUS);
    localparam logic [WIDTH:0]   MaxExt = (WIDTH + 1)'(MODULUS - 1);
    localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] data_q, data_d;
    logic             ovf_q, ovf_d;
    logic             err_q, err_d;

    logic [WIDTH:0] data_ext;
    logic [WIDTH:0] step_ext;
    logic [WIDTH:0] din_ext;
    logic [WIDTH:0] sum;

    always_comb begin
        data_d   = data_q;
        ovf_d    = 1'b0;
        err_d    = 1'b0;
        data_ext = {1'b0, data_q};
        step_ext = {1'b0, step};
        din_ext  = {1'b0, data_in};
        sum      = data_ext + step_ext;

        if (load) begin
            if (din_ext >= ModExt) begin
                data_d = MaxVal;
                err_d  = 1'b1;
            end else begin
                data_d = data_in;
            end
        end else if (en && (step_ext != '0)) begin
            if (step_ext >= ModExt) begin
                err_d = 1'b1;
            end else if (ud) begin
                if (sum > MaxExt) begin
                    ovf_d  = 1'b1;
                    data_d = sat ? MaxVal : WIDTH'(sum - ModExt);
                end else begin
                    data_d = WIDTH'(sum);
                end
            end else begin
                if (step_ext > data_ext) begin
                    ovf_d  = 1'b1;
                    // data + MODULUS - step stays below MODULUS since data < step < MODULUS.
                    data_d = sat ? '0 : WIDTH'(data_ext + ModExt - step_ext);
                end else begin
                    data_d = WIDTH'(data_ext - step_ext);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_q <= '0;
            ovf_q  <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            data_q <= data_d;
            ovf_q  <= ovf_d;
            err_q  <= err_d;
        end
    end

    assign data_out = data_q;
    assign ovf      = ovf_q;
    assign err      = err_q;
    assign at_max   = (data_q == MaxVal);
    assign at_min   = (data_q == '0);

endmodule

// File: tb/tb_updown_counter_mod.sv
// Self-checking bench: directed vector table, reset/hold sequences, and randomized traffic
// compared against an arithmetic reference model (MODULUS=200 and a MODULUS=2^WIDTH copy).
module tb_updown_counter_mod;

    localparam int Mod1 = 200;
    localparam int Mod2 = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       load, en, ud, sat;
    logic [7:0] step, data_in;
    logic [7:0] data_out;
    logic       ovf, err, at_max, at_min;
    logic [3:0] step2, data_in2, data_out2;
    logic       ovf2, err2, at_max2, at_min2;

    assign step2    = step[3:0];
    assign data_in2 = data_in[3:0];

    always #5 clk = ~clk;

    updown_counter_mod #(.WIDTH(8), .MODULUS(200)) u_dut (
        .clk(clk), .reset(reset), .load(load), .en(en), .ud(ud), .sat(sat),
        .step(step), .data_in(data_in), .data_out(data_out), .ovf(ovf), .err(err),
        .at_max(at_max), .at_min(at_min)
    );

    updown_counter_mod #(.WIDTH(4), .MODULUS(16)) u_dut2 (
        .clk(clk), .reset(reset), .load(load), .en(en), .ud(ud), .sat(sat),
        .step(step2), .data_in(data_in2), .data_out(data_out2), .ovf(ovf2), .err(err2),
        .at_max(at_max2), .at_min(at_min2)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit load, en, ud, sat;
        int step, din;
        int dout;
        bit ovf, err;
    } vec_t;

    vec_t vecs[22];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit l, input bit e, input bit u, input bit s,
                         input int st, input int d);
        load = l; en = e; ud = u; sat = s;
        step = 8'(st); data_in = 8'(d);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: signed target value, then wrap or clamp if it leaves 0..mod-1.
    function automatic void model(input int mod, input int cur, input bit l, input bit e,
                                  input bit u, input bit s, input int st, input int d,
                                  output int nxt, output bit o, output bit er);
        int t;
        nxt = cur; o = 1'b0; er = 1'b0;
        if (l) begin
            if (d >= mod) begin
                nxt = mod - 1;
                er  = 1'b1;
            end else begin
                nxt = d;
            end
        end else if (e && st != 0) begin
            if (st >= mod) begin
                er = 1'b1;
            end else begin
                t = u ? cur + st : cur - st;
                if (t < 0 || t >= mod) begin
                    o   = 1'b1;
                    nxt = s ? (u ? mod - 1 : 0) : ((t % mod) + mod) % mod;
                end else begin
                    nxt = t;
                end
            end
        end
    endfunction

    task automatic do_reset();
        reset = 1'b0;
        #3;
        reset = 1'b1;
    endtask

    initial begin
        int  m1, m2, n1, n2;
        bit  o1, e1, o2, e2;

        vecs[0]  = '{1, 0, 0, 0, 0,   199, 199, 0, 0};
        vecs[1]  = '{0, 1, 1, 0, 1,   0,   0,   1, 0};
        vecs[2]  = '{0, 1, 1, 0, 1,   0,   1,   0, 0};
        vecs[3]  = '{1, 0, 0, 0, 0,   5,   5,   0, 0};
        vecs[4]  = '{0, 1, 0, 0, 7,   0,   198, 1, 0};
        vecs[5]  = '{1, 0, 0, 0, 0,   5,   5,   0, 0};
        vecs[6]  = '{0, 1, 0, 1, 7,   0,   0,   1, 0};
        vecs[7]  = '{1, 1, 1, 0, 3,   250, 199, 0, 1};
        vecs[8]  = '{1, 1, 1, 0, 5,   10,  10,  0, 0};
        vecs[9]  = '{1, 0, 0, 0, 0,   100, 100, 0, 0};
        vecs[10] = '{0, 1, 1, 0, 200, 0,   100, 0, 1};
        vecs[11] = '{0, 1, 1, 0, 0,   0,   100, 0, 0};
        vecs[12] = '{1, 0, 0, 0, 0,   190, 190, 0, 0};
        vecs[13] = '{0, 1, 1, 0, 15,  0,   5,   1, 0};
        vecs[14] = '{1, 0, 0, 1, 0,   190, 190, 0, 0};
        vecs[15] = '{0, 1, 1, 1, 15,  0,   199, 1, 0};
        vecs[16] = '{0, 1, 1, 1, 15,  0,   199, 1, 0};
        vecs[17] = '{0, 1, 1, 1, 1,   0,   199, 1, 0};
        vecs[18] = '{0, 0, 1, 1, 1,   0,   199, 0, 0};
        vecs[19] = '{0, 1, 0, 0, 199, 0,   0,   0, 0};
        vecs[20] = '{0, 1, 0, 1, 1,   0,   0,   1, 0};
        vecs[21] = '{0, 0, 0, 1, 1,   0,   0,   0, 0};

        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        #2;
        do_reset();
        check("reset_data", int'(data_out), 0);
        check("reset_ovf", int'(ovf), 0);
        check("reset_err", int'(err), 0);
        check("reset_at_min", int'(at_min), 1);
        check("reset_at_max", int'(at_max), 0);

        foreach (vecs[i]) begin
            drive(vecs[i].load, vecs[i].en, vecs[i].ud, vecs[i].sat, vecs[i].step,
                  vecs[i].din);
            tick();
            check($sformatf("vec%0d_data", i), int'(data_out), vecs[i].dout);
            check($sformatf("vec%0d_ovf", i), int'(ovf), int'(vecs[i].ovf));
            check($sformatf("vec%0d_err", i), int'(err), int'(vecs[i].err));
            check($sformatf("vec%0d_at_max", i), int'(at_max), int'(vecs[i].dout == 199));
            check($sformatf("vec%0d_at_min", i), int'(at_min), int'(vecs[i].dout == 0));
        end

        // Count to 57, then async reset between edges.
        do_reset();
        drive(0, 1, 1, 0, 1, 0);
        repeat (57) tick();
        check("count57", int'(data_out), 57);
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_data", int'(data_out), 0);
        check("async_rst_ovf", int'(ovf), 0);
        check("async_rst_err", int'(err), 0);
        drive(1, 1, 1, 0, 3, 77);
        repeat (3) tick();
        check("rst_hold_data", int'(data_out), 0);
        check("rst_hold_at_min", int'(at_min), 1);
        check("rst_hold_at_max", int'(at_max), 0);
        drive(1, 0, 0, 0, 0, 33);
        reset = 1'b1;
        #1;
        check("rst_release_no_update", int'(data_out), 0);
        tick();
        check("rst_release_first_edge", int'(data_out), 33);

        // Illegal step then idle with toggling inputs.
        drive(1, 0, 0, 0, 0, 100);
        tick();
        drive(0, 1, 1, 0, 200, 0);
        tick();
        check("step200_data", int'(data_out), 100);
        check("step200_err", int'(err), 1);
        for (int k = 0; k < 5; k++) begin
            drive(0, 0, 1'($urandom), 1'($urandom), int'($urandom_range(0, 255)),
                  int'($urandom_range(0, 255)));
            tick();
            check($sformatf("idle%0d_data", k), int'(data_out), 100);
            check($sformatf("idle%0d_ovf", k), int'(ovf), 0);
            check($sformatf("idle%0d_err", k), int'(err), 0);
        end

        // Randomized traffic against the model on both instances.
        do_reset();
        m1 = 0;
        m2 = 0;
        for (int k = 0; k < 3000; k++) begin
            int st;
            bit l, e, u, s;
            int d;
            l = ($urandom_range(0, 7) == 0);
            e = ($urandom_range(0, 3) != 0);
            u = 1'($urandom);
            s = 1'($urandom);
            case ($urandom_range(0, 4))
                0: st = 0;
                1: st = int'($urandom_range(1, 3));
                2: st = int'($urandom_range(195, 255));
                default: st = int'($urandom_range(0, 255));
            endcase
            d = int'($urandom_range(0, 255));
            drive(l, e, u, s, st, d);
            model(Mod1, m1, l, e, u, s, st, d, n1, o1, e1);
            model(Mod2, m2, l, e, u, s, st % 16, d % 16, n2, o2, e2);
            tick();
            m1 = n1;
            m2 = n2;
            check("rnd_data", int'(data_out), m1);
            check("rnd_ovf", int'(ovf), int'(o1));
            check("rnd_err", int'(err), int'(e1));
            check("rnd_at_max", int'(at_max), int'(m1 == Mod1 - 1));
            check("rnd_at_min", int'(at_min), int'(m1 == 0));
            check("rnd_pow2_data", int'(data_out2), m2);
            check("rnd_pow2_ovf", int'(ovf2), int'(o2));
            check("rnd_pow2_err", int'(err2), int'(e2));
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
                m1 = 0;
                m2 = 0;
                check("rnd_rst_data", int'(data_out), 0);
                check("rnd_rst_ovf", int'(ovf), 0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
